// File: rtl/branch_cond_unit_if.sv
// Handshake/bus bundle between the control unit (master) and branch_cond_unit (slave).
interface branch_cond_unit_if #(
  parameter int DATA_W = 32,
  parameter int COND_W = 3
);
  logic [COND_W-1:0] ir_cond;
  logic [DATA_W-1:0] bus_in;
  logic              con_in;
  logic              con_ack;
  logic              con_out;
  logic              con_valid;
  logic              busy;

  modport master (
    output ir_cond, bus_in, con_in, con_ack,
    input  con_out, con_valid, busy
  );

  modport slave (
    input  ir_cond, bus_in, con_in, con_ack,
    output con_out, con_valid, busy
  );
endinterface

// File: rtl/branch_cond_unit.sv
// Registered CON decision: latch Z/N and condition on con_in, evaluate next cycle, hold until con_ack.
// Optional eval/taken statistics counters under BRANCH_COND_STATS_EN.
module branch_cond_unit #(
  parameter int DATA_W = 32,
  parameter int COND_W = 3
) (
  input  logic               clk,
  input  logic               clr,
  branch_cond_unit_if.slave  bus
`ifdef BRANCH_COND_STATS_EN
  ,
  output logic [15:0]        eval_cnt,
  output logic [15:0]        taken_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t            state;
  logic              z_q;
  logic              n_q;
  logic [COND_W-1:0] cond_q;
  logic              con_out_q;
  logic              con_valid_q;
  logic              busy_q;
  logic [2:0]        code;
  logic              result;

  // A 2-bit condition field zero-extends, so only codes 0-3 are reachable.
  assign code = 3'(cond_q);

  always_comb begin
    result = 1'b0;
    case (code)
      3'd0:    result = z_q;
      3'd1:    result = ~z_q;
      3'd2:    result = ~n_q;
      3'd3:    result = n_q;
      3'd4:    result = 1'b1;
      3'd5:    result = 1'b0;
      3'd6:    result = ~n_q & ~z_q;
      default: result = n_q | z_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      cond_q      <= '0;
      con_out_q   <= 1'b0;
      con_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.con_in) begin
            z_q    <= (bus.bus_in == '0);
            n_q    <= bus.bus_in[DATA_W-1];
            cond_q <= bus.ir_cond;
            busy_q <= 1'b1;
            state  <= EVAL;
          end
        end
        EVAL: begin
          con_out_q   <= result;
          con_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= HOLD;
        end
        HOLD: begin
          // A new strobe takes priority; a coincident ack is dropped.
          if (bus.con_in) begin
            z_q         <= (bus.bus_in == '0);
            n_q         <= bus.bus_in[DATA_W-1];
            cond_q      <= bus.ir_cond;
            con_out_q   <= 1'b0;
            con_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state       <= EVAL;
          end else if (bus.con_ack) begin
            con_out_q   <= 1'b0;
            con_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          con_out_q   <= 1'b0;
          con_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.con_out   = con_out_q;
  assign bus.con_valid = con_valid_q;
  assign bus.busy      = busy_q;

`ifdef BRANCH_COND_STATS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      eval_cnt  <= '0;
      taken_cnt <= '0;
    end else if (state == EVAL) begin
      if (eval_cnt != 16'hFFFF) eval_cnt <= eval_cnt + 16'd1;
      if (result && (taken_cnt != 16'hFFFF)) taken_cnt <= taken_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Table-driven bench with an expected-decision scoreboard for branch_cond_unit.
module tb_branch_cond_unit;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   exp_q[$];

  branch_cond_unit_if #(.DATA_W(32), .COND_W(3)) bif ();

`ifdef BRANCH_COND_STATS_EN
  logic [15:0] eval_cnt;
  logic [15:0] taken_cnt;
  branch_cond_unit #(.DATA_W(32), .COND_W(3)) dut (
    .clk(clk), .clr(clr), .bus(bif), .eval_cnt(eval_cnt), .taken_cnt(taken_cnt));
`else
  branch_cond_unit #(.DATA_W(32), .COND_W(3)) dut (
    .clk(clk), .clr(clr), .bus(bif));
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cond;
    logic [31:0] data;
    logic        exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe one evaluation, then wait (bounded) for the decision and score it.
  task automatic do_eval(input logic [2:0] c, input logic [31:0] d, input logic e, input bit ack_after);
    int n;
    bit exp_bit;
    bif.ir_cond = c;
    bif.bus_in  = d;
    bif.con_in  = 1'b1;
    exp_q.push_back(e);
    tick();
    bif.con_in  = 1'b0;
    bif.ir_cond = ~c;
    bif.bus_in  = ~d;
    check("busy_in_eval", {31'd0, bif.busy}, 32'd1);
    n = 0;
    while (!bif.con_valid && n < 4) begin
      tick();
      n++;
    end
    exp_bit = exp_q.pop_front();
    if (!bif.con_valid) begin
      check("valid_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", n, 32'd1);
      check($sformatf("con_out c=%0d d=%0h", c, d), {31'd0, bif.con_out}, {31'd0, exp_bit});
      check("busy_after_eval", {31'd0, bif.busy}, 32'd0);
    end
    if (ack_after) begin
      bif.con_ack = 1'b1;
      tick();
      bif.con_ack = 1'b0;
      check("ack_valid", {31'd0, bif.con_valid}, 32'd0);
      check("ack_out", {31'd0, bif.con_out}, 32'd0);
    end
  endtask

  initial begin
    vec_t vecs[14];
    vecs[0]  = '{3'd0, 32'h0000_0000, 1'b1};
    vecs[1]  = '{3'd0, 32'h0000_0005, 1'b0};
    vecs[2]  = '{3'd3, 32'h8000_0000, 1'b1};
    vecs[3]  = '{3'd2, 32'h8000_0000, 1'b0};
    vecs[4]  = '{3'd7, 32'h8000_0000, 1'b1};
    vecs[5]  = '{3'd6, 32'h8000_0000, 1'b0};
    vecs[6]  = '{3'd6, 32'h0000_0001, 1'b1};
    vecs[7]  = '{3'd1, 32'h0000_0000, 1'b0};
    vecs[8]  = '{3'd1, 32'h0000_0007, 1'b1};
    vecs[9]  = '{3'd4, 32'h0000_1234, 1'b1};
    vecs[10] = '{3'd5, 32'hFFFF_FFFF, 1'b0};
    vecs[11] = '{3'd7, 32'h0000_0000, 1'b1};
    vecs[12] = '{3'd6, 32'h0000_0000, 1'b0};
    vecs[13] = '{3'd2, 32'h7FFF_FFFF, 1'b1};

    bif.ir_cond = '0;
    bif.bus_in  = '0;
    bif.con_in  = 1'b0;
    bif.con_ack = 1'b0;

    // Reset dominates a simultaneous strobe.
    clr = 1'b1;
    bif.con_in = 1'b1;
    tick();
    tick();
    check("rst_out", {31'd0, bif.con_out}, 32'd0);
    check("rst_valid", {31'd0, bif.con_valid}, 32'd0);
    check("rst_busy", {31'd0, bif.busy}, 32'd0);
    clr = 1'b0;
    bif.con_in = 1'b0;
    tick();
    tick();
    tick();
    check("idle_no_valid", {31'd0, bif.con_valid}, 32'd0);
    check("idle_no_busy", {31'd0, bif.busy}, 32'd0);

    // Ack while idle must not start anything.
    bif.con_ack = 1'b1;
    tick();
    bif.con_ack = 1'b0;
    check("ack_idle", {31'd0, bif.con_valid | bif.busy}, 32'd0);

    for (int i = 0; i < 14; i++) do_eval(vecs[i].cond, vecs[i].data, vecs[i].exp, 1'b1);

    // Decision held across idle cycles, then released by ack.
    do_eval(3'd4, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", {31'd0, bif.con_valid}, 32'd1);
      check("hold_out", {31'd0, bif.con_out}, 32'd1);
    end
    bif.con_ack = 1'b1;
    tick();
    bif.con_ack = 1'b0;
    check("rel_valid", {31'd0, bif.con_valid}, 32'd0);
    check("rel_out", {31'd0, bif.con_out}, 32'd0);
    tick();
    check("rel_stays_idle", {31'd0, bif.con_valid | bif.busy}, 32'd0);

    // Strobe and ack together in HOLD: strobe wins.
    do_eval(3'd4, 32'h0, 1'b1, 1'b0);
    bif.ir_cond = 3'd5;
    bif.con_in  = 1'b1;
    bif.con_ack = 1'b1;
    exp_q.push_back(1'b0);
    tick();
    bif.con_in  = 1'b0;
    bif.con_ack = 1'b0;
    check("simul_valid_drop", {31'd0, bif.con_valid}, 32'd0);
    check("simul_out_drop", {31'd0, bif.con_out}, 32'd0);
    check("simul_busy", {31'd0, bif.busy}, 32'd1);
    tick();
    check("simul_valid", {31'd0, bif.con_valid}, 32'd1);
    check("simul_out", {31'd0, bif.con_out}, {31'd0, exp_q.pop_front()});
    tick();
    check("simul_hold", {31'd0, bif.con_valid}, 32'd1);

    // Ack during EVAL is ignored: decision still appears.
    bif.con_ack = 1'b1;
    tick();
    bif.con_ack = 1'b0;
    check("cleared_before_eval", {31'd0, bif.con_valid}, 32'd0);
    bif.ir_cond = 3'd4;
    bif.con_in  = 1'b1;
    tick();
    bif.con_in  = 1'b0;
    bif.con_ack = 1'b1;
    tick();
    bif.con_ack = 1'b0;
    check("ack_eval_ignored", {31'd0, bif.con_valid}, 32'd1);
    check("ack_eval_out", {31'd0, bif.con_out}, 32'd1);
    bif.con_ack = 1'b1;
    tick();
    bif.con_ack = 1'b0;

    // Reset while in EVAL: no decision emerges.
    bif.ir_cond = 3'd4;
    bif.con_in  = 1'b1;
    tick();
    bif.con_in  = 1'b0;
    check("pre_clr_busy", {31'd0, bif.busy}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_eval_valid", {31'd0, bif.con_valid}, 32'd0);
    check("clr_eval_busy", {31'd0, bif.busy}, 32'd0);
    tick();
    tick();
    check("clr_eval_no_pulse", {31'd0, bif.con_valid}, 32'd0);
`ifdef BRANCH_COND_STATS_EN
    check("eval_cnt_clr", {16'd0, eval_cnt}, 32'd0);
    check("taken_cnt_clr", {16'd0, taken_cnt}, 32'd0);
    do_eval(3'd4, 32'h0, 1'b1, 1'b1);
    do_eval(3'd5, 32'h0, 1'b0, 1'b1);
    do_eval(3'd4, 32'h0, 1'b1, 1'b1);
    check("eval_cnt", {16'd0, eval_cnt}, 32'd3);
    check("taken_cnt", {16'd0, taken_cnt}, 32'd2);
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
